frame_vram_wr_sched: RTL
========================

// Module: frame_vram_wr_sched
// PURPOSE
//  Owns the frame VRAM write port and decides which source writes each cycle.
//  On every frame_start it first clears the whole frame to a background colour,
//  one pixel per clock. After the clear it shares the port round-robin between
//  NREQ pixel writers (e.g. platform drawer, player sprite) using a valid/ready handshake.
//  Sits between the game draw engines and frame_vram2 (wr_en/wr_addr/wr_d).
// PARAMETERS
//  WIDHT   320  frame width in pixels (spelling matches frame_vram2)
//  HEIGHT  240  frame height in pixels
//  DW      8    pixel data width
//  NREQ    2    number of write requesters (>=2)
//  AW      localparam = $clog2(WIDHT*HEIGHT); not user-settable
// PORTS
//  clk          in   1         single clock; also drives frame_vram2 wr_clk
//  reset        in   1         asynchronous, active-high reset
//  frame_start  in   1         1-cycle pulse that starts a frame clear
//  bg_color     in   DW        clear colour, sampled on the frame_start cycle
//  req_valid    in   NREQ      requester i has a pixel to write
//  req_addr     in   NREQ*AW   pixel address of requester i, bits [i*AW +: AW]
//  req_data     in   NREQ*DW   pixel data of requester i, bits [i*DW +: DW]
//  req_ready    out  NREQ      one-hot grant; transfer = req_valid[i] & req_ready[i]
//  wr_en        out  1         VRAM write enable (registered)
//  wr_addr      out  AW        VRAM write address (registered)
//  wr_d         out  DW        VRAM write data (registered)
//  clearing     out  1         high while state==CLEAR
//  clear_done   out  1         1-cycle pulse after the last clear write
//  oob          out  1         1-cycle pulse: an out-of-range request was discarded
// BEHAVIOUR
//  Reset (async):
//   - state=ARB, clear counter=0, last-grant pointer=NREQ-1 (requester 0 wins first).
//   - wr_en, wr_addr, wr_d, clearing, clear_done and oob are all 0.
//  State ARB:
//   - req_ready is combinational, one-hot or zero.
//   - Granted requester = first i with req_valid[i], searching from last+1 upward
//     with wrap-around.
//   - req_ready is forced to 0 in any cycle where frame_start=1; frame_start has priority.
//   - On a transfer from requester i: next cycle wr_en=1, wr_addr=req_addr[i],
//     wr_d=req_data[i] (latency 1); last<=i. At most one transfer per cycle.
//   - Requester holding valid keeps req_addr/req_data stable until its ready.
//   - Request with req_addr >= WIDHT*HEIGHT: transfer still completes (ready high)
//     and the pointer still advances; next cycle wr_en=0 and oob=1.
//   - No transfer in a cycle -> next cycle wr_en=0; wr_addr and wr_d hold their values.
//   - frame_start=1 -> latch bg_color, counter<=0, state<=CLEAR.
//  State CLEAR:
//   - req_ready=0 and clearing=1.
//   - Each cycle: registered wr_en=1, wr_addr=counter, wr_d=latched colour;
//     then counter++.
//   - First clear write is visible the cycle after frame_start, at address 0.
//   - Writes are back-to-back, WIDHT*HEIGHT cycles in total, addresses 0..WIDHT*HEIGHT-1.
//   - After the write of the last address is issued: state<=ARB, and in the following
//     cycle clear_done=1 and wr_en=0.
//   - Requests may be granted in that clear_done cycle.
//   - frame_start during CLEAR restarts the clear: counter<=0 and the new bg_color is
//     latched; the next write goes to address 0.
//   - No clear_done pulse is produced for an aborted clear.
//  Counter is AW bits and never wraps past WIDHT*HEIGHT-1; compare against the constant
//  WIDHT*HEIGHT-1.
//  Reset asserted mid-clear aborts immediately: wr_en=0, state=ARB, no clear_done.
//  The pointer only advances on a completed transfer; an idle cycle does not change priority.
// TESTING  (bench: WIDHT=8, HEIGHT=4, NREQ=2, DW=8)
//  1. frame_start with bg_color=8'h25 -> 32 consecutive cycles of wr_en=1 with
//     addr 0..31 and data 8'h25; clear_done=1 on the 33rd cycle; req_ready=0
//     throughout while both requesters are valid.
//  2. Both req_valid held high in ARB -> req_ready alternates 01,10,01,10;
//     each wr_addr/wr_d matches its granted requester, delayed 1 cycle.
//  3. Only req_valid[1] high for 5 cycles -> req_ready[1]=1 every cycle;
//     5 back-to-back writes.
//  4. frame_start(bg=8'h11), then at counter 10 frame_start(bg=8'h7E) -> next write is
//     addr 0 data 8'h7E; 32 more writes follow, then exactly one clear_done.
//  5. req_addr[0]=32 with valid -> ready=1; next cycle wr_en=0 and oob=1; the next
//     grant goes to requester 1.
//  6. reset at clear counter 12 -> wr_en=0 and state ARB at once; after release a
//     request from requester 0 is granted on the first cycle.

Source files
------------

// File: rtl/frame_vram_wr_sched.sv
// frame_vram_wr_sched
// Owns the single write port of the frame VRAM. A frame_start pulse launches a
// full-frame clear to a background colour, one pixel per clock. Outside the
// clear, NREQ pixel writers share the port round-robin.
//
// Handshake: req_ready is combinational and at most one-hot. A transfer from
// requester i happens in a cycle where req_valid[i] & req_ready[i]. A requester
// that raises valid keeps req_addr/req_data stable until it sees ready. The
// pixel appears on wr_en/wr_addr/wr_d one cycle after the transfer.
//
// Clear timing: the write to address 0 is issued in the frame_start cycle itself,
// so it is visible on the port in the next cycle. The remaining addresses follow
// back to back. After the last address is visible, one more CLEAR cycle blocks
// grants and produces the clear_done pulse. The frame must hold at least 2 pixels.
module frame_vram_wr_sched #(
  parameter int WIDHT  = 320,
  parameter int HEIGHT = 240,
  parameter int DW     = 8,
  parameter int NREQ   = 2,
  localparam int AW    = $clog2(WIDHT * HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [DW-1:0]    bg_color,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_d,
  output logic             clearing,
  output logic             clear_done,
  output logic             oob,
  output logic [1:0]       dbg_state
);

  localparam int NPIX = WIDHT * HEIGHT;
  localparam int IW   = $clog2(NREQ);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_q;
  logic          fin_q;      // every clear address issued; the next CLEAR cycle ends the clear
  logic [AW-1:0] cnt_q;      // next clear address to issue
  logic [DW-1:0] color_q;
  logic [IW-1:0] last_q;     // most recently granted requester
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_d_q;
  logic          clear_done_q;
  logic          oob_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_idx;
  logic            found;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            oob_req;

  // Round-robin search that starts just after the last winner and wraps around.
  // A frame_start cycle or any CLEAR cycle grants nothing.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (state_q == ST_ARB && !frame_start) begin
      for (int k = 1; k <= NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[i] && (i == (int'(last_q) + k) % NREQ)) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gnt_idx  = IW'(i);
          end
        end
      end
    end
  end

  // Select the address and data of the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // The compare is one bit wider so it stays meaningful when the pixel count is a power of two.
  assign oob_req = ({1'b0, sel_addr} >= (AW+1)'(NPIX));

  // Main sequencer: the clear walk, the arbitration pointer, and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARB;
      fin_q        <= 1'b0;
      cnt_q        <= '0;
      color_q      <= '0;
      last_q       <= IW'(NREQ - 1);
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_d_q       <= '0;
      clear_done_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      clear_done_q <= 1'b0;
      oob_q        <= 1'b0;
      if (frame_start) begin
        // A new clear starts, or an active clear restarts, by issuing address 0 right away.
        state_q   <= ST_CLEAR;
        fin_q     <= 1'b0;
        color_q   <= bg_color;
        cnt_q     <= AW'(1);
        wr_en_q   <= 1'b1;
        wr_addr_q <= '0;
        wr_d_q    <= bg_color;
      end else if (state_q == ST_CLEAR) begin
        if (fin_q) begin
          state_q      <= ST_ARB;
          fin_q        <= 1'b0;
          clear_done_q <= 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_d_q    <= color_q;
          if (cnt_q == LAST_ADDR) begin
            fin_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
      end else if (found) begin
        // Out-of-range pixels still complete the handshake but never reach the VRAM.
        last_q <= gnt_idx;
        if (oob_req) begin
          oob_q <= 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= sel_addr;
          wr_d_q    <= sel_data;
        end
      end
    end
  end

  assign req_ready  = grant;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_d       = wr_d_q;
  assign clearing   = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign oob        = oob_q;
  assign dbg_state  = {fin_q, state_q};

endmodule
